// File: rtl/aurora_64b66b_reset_pkg.sv
// aurora_64b66b_reset_pkg: state encoding and default timing for the Aurora 64B66B reset sequencer
package aurora_64b66b_reset_pkg;

    typedef enum logic [2:0] {
        GT_RST    = 3'd0,
        SYS_RST   = 3'd1,
        WAIT_LINK = 3'd2,
        LINK_UP   = 3'd3
    } state_t;

    localparam int DEF_DEBOUNCE_LEN    = 4;
    localparam int DEF_GT_RESET_CYCLES = 128;
    localparam int DEF_SYS_RESET_HOLD  = 64;
    localparam int DEF_LINK_TIMEOUT    = 1000000;
    localparam int DEF_CNT_W           = 24;
    localparam int DEF_RETRY_W         = 8;

endpackage

// File: rtl/aurora_64b66b_rst_debounce.sv
// aurora_64b66b_rst_debounce: accepts a request after DEBOUNCE_LEN consecutive high samples, drops it on the first low
module aurora_64b66b_rst_debounce #(
    parameter int DEBOUNCE_LEN = 4
) (
    input  logic init_clk,
    input  logic reset,
    input  logic level,
    output logic req
);

    localparam int W = $clog2(DEBOUNCE_LEN + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge init_clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            req <= 1'b0;
        end else if (!level) begin
            cnt <= '0;
            req <= 1'b0;
        end else if (!req) begin
            cnt <= cnt + 1'b1;
            req <= cnt == W'(DEBOUNCE_LEN - 1);
        end
    end

endmodule

// File: rtl/aurora_64b66b_reset_seq.sv
// aurora_64b66b_reset_seq: sequences gt_reset then sys_reset and supervises link bring-up with timeout retries
module aurora_64b66b_reset_seq
    import aurora_64b66b_reset_pkg::*;
#(
    parameter int DEBOUNCE_LEN    = DEF_DEBOUNCE_LEN,
    parameter int GT_RESET_CYCLES = DEF_GT_RESET_CYCLES,
    parameter int SYS_RESET_HOLD  = DEF_SYS_RESET_HOLD,
    parameter int LINK_TIMEOUT    = DEF_LINK_TIMEOUT,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int RETRY_W         = DEF_RETRY_W
) (
    input  logic               init_clk,
    input  logic               reset,
    input  logic               reset_req_sync,
    input  logic               pma_init_req_sync,
    input  logic               channel_up_sync,
    output logic               gt_reset,
    output logic               sys_reset,
    output logic               link_ok,
    output logic [RETRY_W-1:0] retry_count,
    output logic [2:0]         seq_state
);

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt;
    logic             pma_req, sys_req, hold, timeout, retry_inc;

    aurora_64b66b_rst_debounce #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_pma_db (
        .init_clk (init_clk),
        .reset    (reset),
        .level    (pma_init_req_sync),
        .req      (pma_req)
    );

    aurora_64b66b_rst_debounce #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_sys_db (
        .init_clk (init_clk),
        .reset    (reset),
        .level    (reset_req_sync),
        .req      (sys_req)
    );

    // Requests pre-empt every phase event; a pending request also stalls its own phase at count 0
    always_comb begin
        timeout   = state == WAIT_LINK && !channel_up_sync && cnt == CNT_W'(LINK_TIMEOUT - 1);
        hold      = (state == GT_RST && pma_req) || (state == SYS_RST && sys_req);
        retry_inc = timeout && !pma_req && !sys_req;
        nxt       = state;
        if (pma_req)
            nxt = GT_RST;
        else if (sys_req && state != GT_RST)
            nxt = SYS_RST;
        else
            case (state)
                GT_RST:    nxt = cnt == CNT_W'(GT_RESET_CYCLES - 1) ? SYS_RST : GT_RST;
                SYS_RST:   nxt = cnt == CNT_W'(SYS_RESET_HOLD - 1) ? WAIT_LINK : SYS_RST;
                WAIT_LINK: nxt = channel_up_sync ? LINK_UP : timeout ? GT_RST : WAIT_LINK;
                LINK_UP:   nxt = channel_up_sync ? LINK_UP : WAIT_LINK;
                default:   nxt = GT_RST;
            endcase
    end

    always_ff @(posedge init_clk or posedge reset) begin
        if (reset) begin
            state       <= GT_RST;
            cnt         <= '0;
            gt_reset    <= 1'b1;
            sys_reset   <= 1'b1;
            link_ok     <= 1'b0;
            retry_count <= '0;
        end else begin
            state     <= nxt;
            cnt       <= (nxt != state || hold || state == LINK_UP) ? '0 : cnt + 1'b1;
            gt_reset  <= nxt == GT_RST;
            sys_reset <= nxt == GT_RST || nxt == SYS_RST;
            link_ok   <= nxt == LINK_UP;
            if (retry_inc && !(&retry_count))
                retry_count <= retry_count + 1'b1;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_aurora_64b66b_reset_seq.sv
// tb_aurora_64b66b_reset_seq: scoreboard bench for the reset sequencer with short timing parameters
module tb_aurora_64b66b_reset_seq;

    logic       init_clk = 1'b0;
    logic       reset = 1'b1;
    logic       reset_req_sync = 1'b0;
    logic       pma_init_req_sync = 1'b0;
    logic       channel_up_sync = 1'b0;
    logic       gt_reset, sys_reset, link_ok;
    logic [7:0] retry_count;
    logic [2:0] seq_state;

    int compared = 0;
    int mismatched = 0;
    logic [13:0] sb[$];
    int rq[$];
    logic [13:0] obs;

    assign obs = {gt_reset, sys_reset, link_ok, seq_state, retry_count};

    aurora_64b66b_reset_seq #(
        .DEBOUNCE_LEN    (4),
        .GT_RESET_CYCLES (16),
        .SYS_RESET_HOLD  (8),
        .LINK_TIMEOUT    (100),
        .CNT_W           (24),
        .RETRY_W         (8)
    ) dut (
        .init_clk          (init_clk),
        .reset             (reset),
        .reset_req_sync    (reset_req_sync),
        .pma_init_req_sync (pma_init_req_sync),
        .channel_up_sync   (channel_up_sync),
        .gt_reset          (gt_reset),
        .sys_reset         (sys_reset),
        .link_ok           (link_ok),
        .retry_count       (retry_count),
        .seq_state         (seq_state)
    );

    initial forever #5 init_clk = ~init_clk;

    function automatic logic [13:0] pk(input logic g, input logic s, input logic l,
                                       input logic [2:0] st, input logic [7:0] r);
        return {g, s, l, st, r};
    endfunction

    task automatic tick;
        @(posedge init_clk);
        #1;
    endtask

    task automatic apply_reset(input logic cu);
        reset = 1'b1;
        reset_req_sync = 1'b0;
        pma_init_req_sync = 1'b0;
        channel_up_sync = cu;
        repeat (3) tick;
        reset = 1'b0;
    endtask

    // cycle k after release: 16 GT_RST, 8 SYS_RST, 1 WAIT_LINK, then LINK_UP
    task automatic push_bringup;
        for (int k = 0; k < 30; k++)
            sb.push_back(k < 16 ? pk(1, 1, 0, 0, 0) : k < 24 ? pk(0, 1, 0, 1, 0) :
                         k == 24 ? pk(0, 0, 0, 2, 0) : pk(0, 0, 1, 3, 0));
    endtask

    task automatic test_reset;
        logic [13:0] e;
        reset = 1'b1;
        tick;
        tick;
        repeat (2) sb.push_back(pk(1, 1, 0, 0, 0));
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL reset cyc %0d: got %b/%b/%b/%0d/%0d need %b/%b/%b/%0d/%0d", k,
                         obs[13], obs[12], obs[11], obs[10:8], obs[7:0], e[13], e[12], e[11], e[10:8], e[7:0]);
            end
            tick;
        end
    endtask

    task automatic test_bringup;
        logic [13:0] e;
        apply_reset(1'b1);
        push_bringup();
        for (int k = 0; k < 30; k++) begin
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL bringup cyc %0d: got %b/%b/%b/%0d/%0d need %b/%b/%b/%0d/%0d", k,
                         obs[13], obs[12], obs[11], obs[10:8], obs[7:0], e[13], e[12], e[11], e[10:8], e[7:0]);
            end
            tick;
        end
    endtask

    // each retry period is 16 + 8 + 100 cycles; the count saturates at 255
    task automatic test_retry;
        int   last;
        logic prev;
        last = 0;
        apply_reset(1'b0);
        for (int n = 1; n <= 256; n++) rq.push_back(n > 255 ? 255 : n);
        prev = gt_reset;
        for (int cyc = 1; cyc <= 256 * 124 + 20 && rq.size() > 0; cyc++) begin
            tick;
            if (gt_reset && !prev) begin
                int e;
                e = rq.pop_front();
                compared++;
                if (retry_count !== 8'(e) || seq_state !== 3'd0) begin
                    mismatched++;
                    $display("FAIL retry_count cyc %0d: got rc=%0d st=%0d need rc=%0d st=0",
                             cyc, retry_count, seq_state, e);
                end
                compared++;
                if (cyc - last !== 124) begin
                    mismatched++;
                    $display("FAIL retry_period cyc %0d: got %0d need 124", cyc, cyc - last);
                end
                last = cyc;
            end
            prev = gt_reset;
        end
        compared++;
        if (rq.size() != 0) begin
            mismatched++;
            $display("FAIL retry_timeout: got %0d retries outstanding need 0", rq.size());
            rq.delete();
        end
    endtask

    task automatic test_sys_req;
        logic [13:0] e;
        apply_reset(1'b1);
        repeat (30) tick;
        repeat (10) sb.push_back(pk(0, 0, 1, 3, 0));
        for (int k = 0; k < 10; k++) begin
            reset_req_sync = k < 3;
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL glitch cyc %0d: got %b/%b/%b/%0d/%0d need %b/%b/%b/%0d/%0d", k,
                         obs[13], obs[12], obs[11], obs[10:8], obs[7:0], e[13], e[12], e[11], e[10:8], e[7:0]);
            end
            tick;
        end
        for (int k = 0; k < 20; k++)
            sb.push_back(k < 5 ? pk(0, 0, 1, 3, 0) : k < 15 ? pk(0, 1, 0, 1, 0) :
                         k == 15 ? pk(0, 0, 0, 2, 0) : pk(0, 0, 1, 3, 0));
        for (int k = 0; k < 20; k++) begin
            reset_req_sync = k < 6;
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL sys_req cyc %0d: got %b/%b/%b/%0d/%0d need %b/%b/%b/%0d/%0d", k,
                         obs[13], obs[12], obs[11], obs[10:8], obs[7:0], e[13], e[12], e[11], e[10:8], e[7:0]);
            end
            tick;
        end
    endtask

    task automatic test_both_req;
        logic [13:0] e;
        for (int k = 0; k < 45; k++)
            sb.push_back(k < 5 ? pk(0, 0, 1, 3, 0) : k < 23 ? pk(1, 1, 0, 0, 0) :
                         k < 39 ? pk(0, 1, 0, 1, 0) : k == 39 ? pk(0, 0, 0, 2, 0) : pk(0, 0, 1, 3, 0));
        for (int k = 0; k < 45; k++) begin
            pma_init_req_sync = k < 6;
            reset_req_sync = k < 30;
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL both_req cyc %0d: got %b/%b/%b/%0d/%0d need %b/%b/%b/%0d/%0d", k,
                         obs[13], obs[12], obs[11], obs[10:8], obs[7:0], e[13], e[12], e[11], e[10:8], e[7:0]);
            end
            tick;
        end
    endtask

    task automatic test_link_drop;
        logic [13:0] e;
        for (int k = 0; k < 6; k++)
            sb.push_back(k == 1 ? pk(0, 0, 0, 2, 0) : pk(0, 0, 1, 3, 0));
        for (int k = 0; k < 6; k++) begin
            channel_up_sync = k != 0;
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL link_drop cyc %0d: got %b/%b/%b/%0d/%0d need %b/%b/%b/%0d/%0d", k,
                         obs[13], obs[12], obs[11], obs[10:8], obs[7:0], e[13], e[12], e[11], e[10:8], e[7:0]);
            end
            tick;
        end
    endtask

    task automatic test_mid_reset;
        logic [13:0] e;
        apply_reset(1'b1);
        repeat (21) tick;
        sb.push_back(pk(0, 1, 0, 1, 0));
        sb.push_back(pk(1, 1, 0, 0, 0));
        e = sb.pop_front();
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL pre_reset: got %b/%b/%b/%0d/%0d need %b/%b/%b/%0d/%0d",
                     obs[13], obs[12], obs[11], obs[10:8], obs[7:0], e[13], e[12], e[11], e[10:8], e[7:0]);
        end
        reset = 1'b1;
        #1;
        e = sb.pop_front();
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL async_reset: got %b/%b/%b/%0d/%0d need %b/%b/%b/%0d/%0d",
                     obs[13], obs[12], obs[11], obs[10:8], obs[7:0], e[13], e[12], e[11], e[10:8], e[7:0]);
        end
        tick;
        tick;
        reset = 1'b0;
        push_bringup();
        for (int k = 0; k < 30; k++) begin
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL restart cyc %0d: got %b/%b/%b/%0d/%0d need %b/%b/%b/%0d/%0d", k,
                         obs[13], obs[12], obs[11], obs[10:8], obs[7:0], e[13], e[12], e[11], e[10:8], e[7:0]);
            end
            tick;
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_retry();
        test_sys_req();
        test_both_req();
        test_link_drop();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
